// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: default bus widths,
// reset PC and the fetch FSM state type.
package if_fetch_unit_pkg;

    localparam int          FETCH_ADDR_W   = 32;
    localparam int          FETCH_INST_W   = 32;
    localparam int          FETCH_PRED_W   = 13;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one memory fetch at a time, picks
// the next PC from the branch predictor and presents results to decode.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INST_W   = FETCH_INST_W,
    parameter int                PRED_W   = FETCH_PRED_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [INST_W-1:0] mem_inst,
    output logic [ADDR_W-1:0] pred_addr,
    input  logic              pred_jmp,
    input  logic [PRED_W-1:0] pred_target,
    input  logic              br_flush,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_pred_jmp,
    output logic [ADDR_W-1:0] id_pred_pc
);

    function automatic logic [ADDR_W-1:0] predict_next(input logic [ADDR_W-1:0] pc,
                                                       input logic              jmp,
                                                       input logic [PRED_W-1:0] tgt);
        if (jmp) begin
            return {pc[ADDR_W-1:PRED_W], tgt};
        end
        return pc + ADDR_W'(4);
    endfunction

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              kill_q, kill_d;
    logic              mem_req_q, mem_req_d;
    logic              hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [INST_W-1:0] hold_inst_q, hold_inst_d;
    logic              hold_pred_jmp_q, hold_pred_jmp_d;
    logic [ADDR_W-1:0] hold_pred_pc_q, hold_pred_pc_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              id_pred_jmp_q, id_pred_jmp_d;
    logic [ADDR_W-1:0] id_pred_pc_q, id_pred_pc_d;

    logic              slot_free;
    logic [ADDR_W-1:0] next_pc;

    assign slot_free = !id_valid_q || id_ready;
    assign next_pc   = predict_next(pc_q, pred_jmp, pred_target);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        kill_d          = kill_q;
        mem_req_d       = mem_req_q;
        hold_valid_d    = hold_valid_q;
        hold_pc_d       = hold_pc_q;
        hold_inst_d     = hold_inst_q;
        hold_pred_jmp_d = hold_pred_jmp_q;
        hold_pred_pc_d  = hold_pred_pc_q;
        id_valid_d      = id_valid_q && !id_ready;
        id_pc_d         = id_pc_q;
        id_inst_d       = id_inst_q;
        id_pred_jmp_d   = id_pred_jmp_q;
        id_pred_pc_d    = id_pred_pc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!hold_valid_q) begin
                    mem_req_d = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        pc_d = next_pc;
                        if (slot_free) begin
                            id_valid_d    = 1'b1;
                            id_pc_d       = pc_q;
                            id_inst_d     = mem_inst;
                            id_pred_jmp_d = pred_jmp;
                            id_pred_pc_d  = next_pc;
                        end else begin
                            hold_valid_d    = 1'b1;
                            hold_pc_d       = pc_q;
                            hold_inst_d     = mem_inst;
                            hold_pred_jmp_d = pred_jmp;
                            hold_pred_pc_d  = next_pc;
                            state_d         = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    id_valid_d    = 1'b1;
                    id_pc_d       = hold_pc_q;
                    id_inst_d     = hold_inst_q;
                    id_pred_jmp_d = hold_pred_jmp_q;
                    id_pred_pc_d  = hold_pred_pc_q;
                    hold_valid_d  = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A redirect wins over everything; an outstanding fetch must still drain.
        if (br_flush) begin
            pc_d         = br_target;
            id_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            if (state_q == ST_WAIT && !mem_done) begin
                kill_d    = 1'b1;
                mem_req_d = 1'b1;
                state_d   = ST_WAIT;
            end else begin
                kill_d    = 1'b0;
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            hold_valid_q  <= 1'b0;
            id_valid_q    <= 1'b0;
            id_pc_q       <= '0;
            id_inst_q     <= '0;
            id_pred_jmp_q <= 1'b0;
            id_pred_pc_q  <= '0;
        end else if (rdy) begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            mem_req_q     <= mem_req_d;
            hold_valid_q  <= hold_valid_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_pred_jmp_q <= id_pred_jmp_d;
            id_pred_pc_q  <= id_pred_pc_d;
        end
    end

    // Hold buffer contents are qualified by hold_valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            hold_pc_q       <= hold_pc_d;
            hold_inst_q     <= hold_inst_d;
            hold_pred_jmp_q <= hold_pred_jmp_d;
            hold_pred_pc_q  <= hold_pred_pc_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign pred_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_pred_jmp = id_pred_jmp_q;
    assign id_pred_pc  = id_pred_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory controller and predictor models around the DUT,
// with an instruction-stream reference checking every beat decode accepts.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_inst;
    logic [31:0] pred_addr;
    logic        pred_jmp;
    logic [12:0] pred_target;
    logic        br_flush;
    logic [31:0] br_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred_jmp;
    logic [31:0] id_pred_pc;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_inst(mem_inst),
        .pred_addr(pred_addr), .pred_jmp(pred_jmp), .pred_target(pred_target),
        .br_flush(br_flush), .br_target(br_target),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_pred_jmp(id_pred_jmp), .id_pred_pc(id_pred_pc)
    );

    int errors = 0;
    int checks = 0;

    // Predictor mode: 0 never taken, 1 pseudo-random table, 2 only 0x1000 -> 0x0040
    int pred_mode  = 0;
    int flush_mode = 0;
    int lat_mode   = 3;   // 0 = random latency 1..4

    // Memory controller model
    bit          mc_busy;
    int          mc_cnt;
    logic [31:0] mc_addr;
    int          n_starts;

    // Reference stream
    logic [31:0] exp_pc;     // PC of next instruction decode should accept
    logic [31:0] fetch_exp;  // next address that should be requested
    int          n_beats;
    logic [31:0] lb_pc, lb_ppc;
    logic        lb_pj;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_ABCD;
    endfunction

    function automatic logic pj_f(input int mode, input logic [31:0] a);
        if (mode == 1) return (a[5:2] == 4'b0110);
        if (mode == 2) return (a == 32'h0000_1000);
        return 1'b0;
    endfunction

    function automatic logic [12:0] pt_f(input int mode, input logic [31:0] a);
        if (mode == 2) return 13'h0040;
        return 13'((a[12:0] * 13'd7) ^ 13'h0A53);
    endfunction

    // Predicted-taken replaces the low 13 bits; otherwise sequential, wrapping mod 2^32.
    function automatic logic [31:0] npc_f(input int mode, input logic [31:0] a);
        if (pj_f(mode, a)) return {a[31:13], pt_f(mode, a)};
        return a + 32'd4;
    endfunction

    assign pred_jmp    = pj_f(pred_mode, pred_addr);
    assign pred_target = pt_f(pred_mode, pred_addr);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // One clock: check any handshake at the edge, then advance the memory model.
    task automatic step();
        logic e_rdy, e_done;
        @(negedge clk);
        e_rdy  = rdy;
        e_done = mem_done;
        if (rdy && id_valid && id_ready) begin
            chk("beat_pc",   id_pc,       exp_pc);
            chk("beat_inst", id_inst,     mem_f(exp_pc));
            chk("beat_pj",   id_pred_jmp, pj_f(pred_mode, exp_pc));
            chk("beat_ppc",  id_pred_pc,  npc_f(pred_mode, exp_pc));
            lb_pc  = id_pc;
            lb_pj  = id_pred_jmp;
            lb_ppc = id_pred_pc;
            exp_pc = npc_f(pred_mode, exp_pc);
            n_beats++;
        end
        if (rdy && br_flush) begin
            exp_pc    = br_target;
            fetch_exp = br_target;
            pred_mode = flush_mode;
        end
        @(posedge clk);
        #1;
        if (e_rdy) begin
            if (e_done) mc_busy = 1'b0;
            else if (mc_busy) mc_cnt--;
            if (!mc_busy && mem_req) begin
                chk("req_addr", mem_addr, fetch_exp);
                fetch_exp = npc_f(pred_mode, fetch_exp);
                mc_busy   = 1'b1;
                mc_addr   = mem_addr;
                mc_cnt    = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
                n_starts++;
            end
            mem_done = mc_busy && (mc_cnt == 1);
            mem_inst = mem_done ? mem_f(mc_addr) : $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req",   mem_req,     1'b0);
        chk("rst_mem_addr",  mem_addr,    32'h0);
        chk("rst_pred_addr", pred_addr,   32'h0);
        chk("rst_id_valid",  id_valid,    1'b0);
        chk("rst_id_pc",     id_pc,       32'h0);
        chk("rst_id_inst",   id_inst,     32'h0);
        chk("rst_id_pj",     id_pred_jmp, 1'b0);
        chk("rst_id_ppc",    id_pred_pc,  32'h0);
        mc_busy   = 1'b0;
        mc_cnt    = 0;
        mem_done  = 1'b0;
        exp_pc    = 32'h0;
        fetch_exp = 32'h0;
        br_flush  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int target;
        target = n_beats + n;
        for (int i = 0; i < budget && n_beats < target; i++) step();
        chk(tag, 128'(n_beats >= target), 128'(1));
    endtask

    initial begin
        int s0, i;
        logic [127:0] snap_a, snap_b, snap_c;

        rdy = 1'b1; id_ready = 1'b1; br_flush = 1'b0; br_target = '0;
        mem_done = 1'b0; mem_inst = '0; n_starts = 0; n_beats = 0;
        lb_pc = '0; lb_pj = 1'b0; lb_ppc = '0;

        // Reset and sequential fetch with 3-cycle memory
        do_reset();
        wait_beats(4, 80, "seq_progress");
        chk("seq_last_pc", lb_pc, 32'hC);

        // Decode stall: second instruction parks in the hold buffer
        for (i = 0; i < 40 && !id_valid; i++) step();
        chk("stall_first_valid", id_valid, 1'b1);
        id_ready = 1'b0;
        s0 = n_starts;
        repeat (5) step();
        chk("stall_one_req", 128'(n_starts - s0), 128'(1));
        chk("stall_no_req",  mem_req,  1'b0);
        chk("stall_valid",   id_valid, 1'b1);
        chk("stall_front",   id_pc,    exp_pc);
        id_ready = 1'b1;
        wait_beats(3, 60, "stall_release");

        // Freeze mid-WAIT
        for (i = 0; i < 40 && !(mc_busy && mc_cnt == 2); i++) step();
        chk("freeze_in_wait", mem_req, 1'b1);
        snap_a = {mem_req, id_valid, id_pred_jmp, mem_addr};
        snap_b = {id_pc, id_inst};
        snap_c = {id_pred_pc, pred_addr};
        rdy = 1'b0;
        repeat (4) begin
            step();
            chk("freeze_ctl",  {mem_req, id_valid, id_pred_jmp, mem_addr}, snap_a);
            chk("freeze_data", {id_pc, id_inst}, snap_b);
            chk("freeze_pc",   {id_pred_pc, pred_addr}, snap_c);
        end
        rdy = 1'b1;
        wait_beats(3, 60, "freeze_resume");

        // Flush while a fetch is outstanding
        for (i = 0; i < 40 && !(mc_busy && mc_cnt == 3); i++) step();
        br_flush = 1'b1; br_target = 32'h200;
        step();
        br_flush = 1'b0;
        chk("kill_req_held", mem_req, 1'b1);
        s0 = n_starts;
        for (i = 0; i < 20 && n_starts == s0; i++) begin
            chk("kill_no_valid", id_valid, 1'b0);
            step();
        end
        chk("kill_refetch", 128'(n_starts > s0), 128'(1));
        wait_beats(1, 40, "kill_beat");
        chk("kill_beat_pc", lb_pc, 32'h200);

        // Predicted-taken branch at 0x1000
        flush_mode = 2; br_flush = 1'b1; br_target = 32'h1000;
        step();
        br_flush = 1'b0;
        wait_beats(1, 40, "pred_beat");
        chk("pred_pc",   lb_pc,  32'h1000);
        chk("pred_jmp",  lb_pj,  1'b1);
        chk("pred_ppc",  lb_ppc, 32'h40);
        wait_beats(1, 40, "pred_next");
        chk("pred_next_pc", lb_pc, 32'h40);

        // Wraparound at the top of the address space
        flush_mode = 0; br_flush = 1'b1; br_target = 32'hFFFF_FFFC;
        step();
        br_flush = 1'b0;
        wait_beats(1, 40, "wrap_beat");
        chk("wrap_ppc", lb_ppc, 32'h0);
        wait_beats(1, 40, "wrap_next");
        chk("wrap_next_pc", lb_pc, 32'h0);

        // Randomised traffic
        lat_mode = 0; flush_mode = 1;
        br_flush = 1'b1; br_target = 32'h0000_3000;
        step();
        for (int k = 0; k < 1500; k++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            id_ready  = ($urandom_range(0, 9) < 7);
            br_flush  = ($urandom_range(0, 39) == 0);
            br_target = $urandom;
            step();
        end
        rdy = 1'b1; id_ready = 1'b1; br_flush = 1'b0;
        wait_beats(3, 80, "rand_drain");

        // Asynchronous reset in the middle of a fetch
        lat_mode = 3;
        for (i = 0; i < 40 && !(mc_busy && mc_cnt >= 2); i++) step();
        chk("midrst_busy", mem_req, 1'b1);
        #2;
        do_reset();
        wait_beats(2, 60, "midrst_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
